mips_boot_loader: RTL and testbench

Program loader that sits directly upstream of the Mips_Processor core. It takes a word stream from the host over a valid/ready handshake and writes it into the core's unified instruction/data memory. It holds the core in reset while loading, checks a 16-bit checksum, then releases the core. On a checksum or length error the core stays in reset and `error` is asserted.

---
 rtl/mips_loader_pkg.sv | 16 +
 rtl/loader_checksum.sv | 25 ++
 rtl/mips_boot_loader.sv | 133 +++++++++++++
 tb/tb_mips_boot_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_loader_pkg.sv
// Shared types and defaults for the Mips_Processor program loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_t;

  localparam logic [15:0] DEF_BASE_ADDR = 16'h0000;
  localparam int          DEF_MAX_WORDS = 1024;

endpackage

// File: rtl/loader_checksum.sv
// Modulo-2^W running sum of program words; clear has priority over add.
module loader_checksum #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rest,
  input  logic         i_clr,
  input  logic         i_add,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_sum
);

  logic [W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (rest || i_clr) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/mips_boot_loader.sv
// Streams a length-prefixed, checksummed program into core memory and
// releases the core from reset only after the checksum matches.
module mips_boot_loader
  import mips_loader_pkg::*;
#(
  parameter int                WORD_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
  parameter int                MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_rest,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam logic [WORD_W:0] MAX_LEN = (WORD_W + 1)'(MAX_WORDS);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;
  logic                r_core_rest;
  logic                r_done;
  logic                r_error;
  logic [ADDR_W-1:0]   r_count;
  logic [WORD_W-1:0]   r_len;
  logic [ADDR_W-1:0]   w_count_inc;
  logic [WORD_W-1:0]   w_sum;
  logic                w_accept;
  logic                w_clr;
  logic                w_add;

  assign w_accept    = in_valid && r_in_ready;
  assign w_clr       = (r_state == ST_LEN) && w_accept;
  assign w_add       = (r_state == ST_LOAD) && w_accept;
  assign w_count_inc = r_count + ADDR_W'(1);

  loader_checksum #(
    .W (WORD_W)
  ) u_checksum (
    .clk    (clk),
    .rest   (rest),
    .i_clr  (w_clr),
    .i_add  (w_add),
    .i_data (in_data),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rest) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // start only restarts from the resting states; mid-load it is ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) w_state_next = ST_LEN;
      end
      ST_LEN: begin
        if (w_accept) begin
          if ({1'b0, in_data} > MAX_LEN) w_state_next = ST_ERROR;
          else if (in_data == '0)        w_state_next = ST_CHECK;
          else                           w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_accept && (w_count_inc == ADDR_W'(r_len))) w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_accept) w_state_next = (in_data == w_sum) ? ST_RUN : ST_ERROR;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track state entry.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_core_rest <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_count     <= '0;
      r_len       <= '0;
    end else begin
      r_in_ready  <= (w_state_next == ST_LEN) || (w_state_next == ST_LOAD) ||
                     (w_state_next == ST_CHECK);
      r_core_rest <= (w_state_next != ST_RUN);
      r_done      <= (w_state_next == ST_RUN);
      r_error     <= (w_state_next == ST_ERROR);
      r_mem_we    <= w_add;
      if (w_add) begin
        r_mem_addr  <= BASE_ADDR + {r_count[ADDR_W-2:0], 1'b0};
        r_mem_wdata <= in_data;
        r_count     <= w_count_inc;
      end
      if (w_clr) begin
        r_len   <= in_data;
        r_count <= '0;
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign core_rest    = r_core_rest;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_count;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Scoreboard bench: two loaders (base 0x0000 and 0xFFFC) share one host stream.
module tb_mips_boot_loader;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rest, start, in_valid;
  logic [15:0] in_data;

  logic        a_in_ready, a_mem_we, a_core_rest, a_done, a_error;
  logic [15:0] a_mem_addr, a_mem_wdata, a_words;
  logic        b_in_ready, b_mem_we, b_core_rest, b_done, b_error;
  logic [15:0] b_mem_addr, b_mem_wdata, b_words;

  int n_checks = 0;
  int n_fail   = 0;
  wr_t q_a[$];
  wr_t q_b[$];
  logic [15:0] prog [8];
  int gap_tab [8] = '{1, 0, 2, 0, 3, 1, 0, 2};

  always #5 clk = ~clk;

  mips_boot_loader u_dut_a (
    .clk(clk), .rest(rest), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .core_rest(a_core_rest), .done(a_done),
    .error(a_error), .words_loaded(a_words)
  );

  mips_boot_loader #(.BASE_ADDR(16'hFFFC)) u_dut_b (
    .clk(clk), .rest(rest), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .core_rest(b_core_rest), .done(b_done),
    .error(b_error), .words_loaded(b_words)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (a_mem_we) begin
      chk("a_write_expected", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("a_wr_addr", a_mem_addr, e.addr);
        chk("a_wr_data", a_mem_wdata, e.data);
        $display("write a: addr=%h data=%h", a_mem_addr, a_mem_wdata);
      end
    end
    if (b_mem_we) begin
      chk("b_write_expected", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("b_wr_addr", b_mem_addr, e.addr);
        chk("b_wr_data", b_mem_wdata, e.data);
        $display("write b: addr=%h data=%h", b_mem_addr, b_mem_wdata);
      end
    end
  end

  task automatic status(input string tag, input bit d, input bit e, input bit cr,
                        input bit rdy, input int wl);
    chk({tag, ".a_done"},      a_done, d);
    chk({tag, ".a_error"},     a_error, e);
    chk({tag, ".a_core_rest"}, a_core_rest, cr);
    chk({tag, ".a_in_ready"},  a_in_ready, rdy);
    chk({tag, ".a_words"},     a_words, wl);
    chk({tag, ".b_done"},      b_done, d);
    chk({tag, ".b_error"},     b_error, e);
    chk({tag, ".b_core_rest"}, b_core_rest, cr);
    chk({tag, ".b_in_ready"},  b_in_ready, rdy);
    chk({tag, ".b_words"},     b_words, wl);
    $display("status %s: done=%b error=%b core_rest=%b ready=%b words=%0d",
             tag, a_done, a_error, a_core_rest, a_in_ready, a_words);
  endtask

  task automatic reset_vals(input string tag);
    status(tag, 0, 0, 1, 0, 0);
    chk({tag, ".a_mem_we"},    a_mem_we, 0);
    chk({tag, ".a_mem_addr"},  a_mem_addr, 0);
    chk({tag, ".a_mem_wdata"}, a_mem_wdata, 0);
    chk({tag, ".b_mem_we"},    b_mem_we, 0);
    chk({tag, ".b_mem_addr"},  b_mem_addr, 0);
    chk({tag, ".b_mem_wdata"}, b_mem_wdata, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one word after 'gap' idle cycles and hold it until accepted.
  task automatic send(input logic [15:0] w, input int gap, output int waits);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    waits    = 0;
    while (!a_in_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready within 40 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load(input bit do_start, input int n, input logic [15:0] len_word,
                      input bit send_cs, input logic [15:0] csum, input bit gaps);
    int waits;
    logic [15:0] off;
    if (do_start) pulse_start();
    send(len_word, 0, waits);
    for (int i = 0; i < n; i++) begin
      off = 16'(2 * i);
      q_a.push_back({16'h0000 + off, prog[i]});
      q_b.push_back({16'hFFFC + off, prog[i]});
      send(prog[i], gaps ? gap_tab[i] : 0, waits);
      if (!gaps) chk("burst_ready_waits", waits, 0);
    end
    if (send_cs) send(csum, gaps ? 1 : 0, waits);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    rest = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    repeat (3) @(negedge clk);
    reset_vals("reset");
    rest = 1'b0;

    // Host offers data while idle: nothing may be accepted or written.
    in_valid = 1'b1; in_data = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", a_in_ready, 0);
    end
    in_valid = 1'b0;

    prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333;
    load(1, 3, 16'd3, 1, 16'h6666, 0);
    status("normal", 1, 0, 0, 0, 3);

    pulse_start();
    status("restart_from_run", 0, 0, 1, 1, 3);
    load(0, 3, 16'd3, 1, 16'h6665, 0);
    status("bad_checksum", 0, 1, 1, 0, 3);

    load(1, 3, 16'd3, 1, 16'h6666, 1);
    status("reload_gaps", 1, 0, 0, 0, 3);

    load(1, 0, 16'd0, 1, 16'h0000, 0);
    status("len_zero", 1, 0, 0, 0, 0);

    load(1, 0, 16'd1025, 0, 16'h0000, 0);
    status("len_too_big", 0, 1, 1, 0, 0);

    prog[0] = 16'hA001; prog[1] = 16'hA002; prog[2] = 16'hA003;
    prog[3] = 16'hA004; prog[4] = 16'hA005;
    load(1, 2, 16'd5, 0, 16'h0000, 0);
    start = 1'b1;  // ignored mid-load
    @(negedge clk);
    start = 1'b0;
    status("start_in_load", 0, 0, 1, 1, 2);
    rest = 1'b1;
    @(negedge clk);
    reset_vals("mid_reset");
    rest = 1'b0;
    in_valid = 1'b1; in_data = 16'hBEEF;
    repeat (2) @(negedge clk);
    chk("post_reset_ready", a_in_ready, 0);
    in_valid = 1'b0;

    prog[0] = 16'h0001; prog[1] = 16'hFFFF; prog[2] = 16'h8000; prog[3] = 16'h7FFF;
    load(1, 4, 16'd4, 1, 16'hFFFF, 1);
    status("final_load", 1, 0, 0, 0, 4);

    repeat (2) @(negedge clk);
    chk("a_writes_drained", q_a.size(), 0);
    chk("b_writes_drained", q_b.size(), 0);
    waits = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
